// File: rtl/sobel_edge_stream.sv
// rtl/sobel_edge_stream.sv - streaming 3x3 Sobel edge detector with internal line buffers
module sobel_edge_stream #(
    parameter int PIXEL_W = 8,
    parameter int LINE_W  = 64,
    parameter int FRAME_H = 48,
    parameter int SHIFT   = 12,
    localparam int GRAD_W = PIXEL_W + 3,
    localparam int SQ_W   = 2 * PIXEL_W + 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               mode,
    input  logic [SQ_W-1:0]    threshold,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_sof,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_eof,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int COL_W  = $clog2(LINE_W);
    localparam int ROW_W  = $clog2(FRAME_H);
    // Squares are formed at twice the gradient width, one bit wider than SQ_W,
    // so that the spare top bit doubles as the zero pad for the threshold compare.
    localparam int PROD_W = 2 * GRAD_W;
    localparam logic [PROD_W-1:0] PIX_MAX = {{(PROD_W - PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};

    logic               adv;
    logic               accept;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   pos_col;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   pos_row;

    // line1 holds row r-1, line2 holds row r-2, both indexed by column
    logic [PIXEL_W-1:0] line1 [LINE_W];
    logic [PIXEL_W-1:0] line2 [LINE_W];

    // win[0]=row r-2, win[1]=row r-1, win[2]=row r; [..][0]=col c-2, [..][2]=col c
    logic [PIXEL_W-1:0] win [3][3];
    logic               s1_valid, s1_border, s1_eof, s1_mode;
    logic [SQ_W-1:0]    s1_thr;

    logic signed [GRAD_W-1:0] gx_c, gy_c;
    logic signed [GRAD_W-1:0] s2_gx, s2_gy;
    logic               s2_valid, s2_border, s2_eof, s2_mode;
    logic [SQ_W-1:0]    s2_thr;

    logic signed [PROD_W-1:0] gx_e, gy_e;
    logic [PROD_W-1:0]  sq_c;
    logic [PROD_W-1:0]  s3_sq;
    logic               s3_valid, s3_border, s3_eof, s3_mode;
    logic [SQ_W-1:0]    s3_thr;

    logic [PROD_W-1:0]  scaled;
    logic [PIXEL_W-1:0] result_c;

    // The whole pipeline moves in lockstep whenever the output slot can take a new value.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // A start-of-frame pixel forces position (0,0) whatever the counters say.
    assign pos_col = in_sof ? '0 : col;
    assign pos_row = in_sof ? '0 : row;

    // Zero-extends a pixel into the signed gradient width.
    function automatic logic signed [GRAD_W-1:0] px(input logic [PIXEL_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // Line buffer update: the row above shifts down one buffer, the new pixel fills line1.
    always_ff @(posedge clock) begin
        if (accept) begin
            line1[pos_col] <= in_pixel;
            line2[pos_col] <= line1[pos_col];
        end
    end

    // Stage 1: position counters, window shift and border/eof flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col      <= '0;
            row      <= '0;
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                if (pos_col == COL_W'(LINE_W - 1)) begin
                    col <= '0;
                    row <= (pos_row == ROW_W'(FRAME_H - 1)) ? '0 : pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= line2[pos_col];
                win[1][2] <= line1[pos_col];
                win[2][2] <= in_pixel;
                s1_border <= (pos_row <= ROW_W'(1)) || (pos_col <= COL_W'(1));
                s1_eof    <= (pos_row == ROW_W'(FRAME_H - 1)) && (pos_col == COL_W'(LINE_W - 1));
                s1_mode   <= mode;
                s1_thr    <= threshold;
            end
        end
    end

    // Horizontal and vertical Sobel gradients over the registered window.
    always_comb begin
        gx_c = (px(win[0][2]) + (px(win[1][2]) <<< 1) + px(win[2][2]))
             - (px(win[0][0]) + (px(win[1][0]) <<< 1) + px(win[2][0]));
        gy_c = (px(win[2][0]) + (px(win[2][1]) <<< 1) + px(win[2][2]))
             - (px(win[0][0]) + (px(win[0][1]) <<< 1) + px(win[0][2]));
    end

    // Stage 2: register the gradients with the flags that travel alongside.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_gx     <= gx_c;
            s2_gy     <= gy_c;
            s2_border <= s1_border;
            s2_eof    <= s1_eof;
            s2_mode   <= s1_mode;
            s2_thr    <= s1_thr;
        end
    end

    assign gx_e = {{GRAD_W{s2_gx[GRAD_W-1]}}, s2_gx};
    assign gy_e = {{GRAD_W{s2_gy[GRAD_W-1]}}, s2_gy};
    assign sq_c = $unsigned(gx_e * gx_e) + $unsigned(gy_e * gy_e);

    // Stage 3: register the squared magnitude.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s3_valid <= 1'b0;
        end else if (adv) begin
            s3_valid  <= s2_valid;
            s3_sq     <= sq_c;
            s3_border <= s2_border;
            s3_eof    <= s2_eof;
            s3_mode   <= s2_mode;
            s3_thr    <= s2_thr;
        end
    end

    // Result selection: border forces zero, then threshold or saturating scale.
    always_comb begin
        scaled = s3_sq >> SHIFT;
        if (s3_border) begin
            result_c = '0;
        end else if (s3_mode) begin
            result_c = (s3_sq >= {1'b0, s3_thr}) ? '1 : '0;
        end else if (scaled > PIX_MAX) begin
            result_c = '1;
        end else begin
            result_c = scaled[PIXEL_W-1:0];
        end
    end

    // Output register: holds its value while the downstream stalls.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_eof   <= 1'b0;
        end else if (adv) begin
            out_valid <= s3_valid;
            out_pixel <= result_c;
            out_eof   <= s3_valid && s3_eof;
        end
    end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb/tb_sobel_edge_stream.sv - directed self-checking bench for sobel_edge_stream
module tb_sobel_edge_stream;
    localparam int PW   = 8;
    localparam int LW   = 8;
    localparam int FH   = 6;
    localparam int SH   = 12;
    localparam int SQW  = 2 * PW + 5;
    localparam int NPIX = LW * FH;
    localparam int BUDGET = 3000;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           mode;
    logic [SQW-1:0] threshold;
    logic [PW-1:0]  in_pixel;
    logic           in_sof;
    logic           in_valid;
    logic           in_ready;
    logic [PW-1:0]  out_pixel;
    logic           out_eof;
    logic           out_valid;
    logic           out_ready;

    always #5 clock = ~clock;

    sobel_edge_stream #(
        .PIXEL_W (PW),
        .LINE_W  (LW),
        .FRAME_H (FH),
        .SHIFT   (SH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode      (mode),
        .threshold (threshold),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_eof   (out_eof),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int img [FH][LW];
    int st_pix[$], st_sof[$], st_mode[$], st_thr[$];
    int ex_pix[$], ex_eof[$], got_pix[$], got_eof[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Straight 2-D Sobel on the reference image at accepted position (r,c).
    function automatic int sobel_ref(input int r, input int c, input int md, input int thr);
        int p [3][3];
        int gx, gy, sq, v;
        if (r <= 1 || c <= 1) return 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                p[dr][dc] = img[r - 2 + dr][c - 2 + dc];
        gx = p[0][2] + 2 * p[1][2] + p[2][2] - p[0][0] - 2 * p[1][0] - p[2][0];
        gy = p[2][0] + 2 * p[2][1] + p[2][2] - p[0][0] - 2 * p[0][1] - p[0][2];
        sq = gx * gx + gy * gy;
        if (md != 0) return (sq >= thr) ? 255 : 0;
        v = sq >> SH;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int gp(input int k);
        return (k < got_pix.size()) ? got_pix[k] : -1;
    endfunction

    // 0: flat 100, 1: vertical step at col 4, 2: bright upper-left triangle
    task automatic set_img(input int kind);
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < LW; c++)
                case (kind)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c >= 4) ? 255 : 0;
                    default: img[r][c] = (r + c <= 6) ? 255 : 0;
                endcase
    endtask

    task automatic clear_q();
        st_pix.delete(); st_sof.delete(); st_mode.delete(); st_thr.delete();
        ex_pix.delete(); ex_eof.delete(); got_pix.delete(); got_eof.delete();
    endtask

    task automatic add_seq(input int n, input int sof_first, input int md, input int thr);
        for (int k = 0; k < n; k++) begin
            int r, c;
            r = k / LW;
            c = k % LW;
            st_pix.push_back(img[r][c]);
            st_sof.push_back((k == 0) ? sof_first : 0);
            st_mode.push_back(md);
            st_thr.push_back(thr);
            ex_pix.push_back(sobel_ref(r, c, md, thr));
            ex_eof.push_back((r == FH - 1 && c == LW - 1) ? 1 : 0);
        end
    endtask

    // Streams st_* and collects outputs; optional 1,0,0,1 out_ready pattern and
    // a reset pulse right after the last accept.
    task automatic run(input string name, input bit stall, input bit rst_after);
        int si = 0, cyc = 0, first_acc = -1, first_out = -1, extra = 0;
        while ((si < st_pix.size() || got_pix.size() < ex_pix.size()) && cyc < BUDGET) begin
            @(negedge clock);
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            in_valid  = (si < st_pix.size());
            if (in_valid) begin
                in_pixel  = PW'(st_pix[si]);
                in_sof    = st_sof[si][0];
                mode      = st_mode[si][0];
                threshold = SQW'(st_thr[si]);
            end else begin
                in_sof = 1'b0;
            end
            #1;
            chk($sformatf("%s in_ready c%0d", name, cyc), in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                got_pix.push_back(out_pixel);
                got_eof.push_back(out_eof);
                if (first_out < 0) first_out = cyc;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                si++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk({name, " budget"}, cyc < BUDGET, 1);
        // accept edge -> output register 3 edges later, seen one loop pass after that
        if (!stall) chk({name, " latency"}, first_out - first_acc, 4);
        if (rst_after) begin
            reset_n = 1'b0;
            @(negedge clock);
            #1;
            chk({name, " flush valid"}, out_valid, 0);
            chk({name, " flush pixel"}, out_pixel, 0);
            reset_n = 1'b1;
        end else begin
            repeat (6) begin
                @(negedge clock);
                out_ready = 1'b1;
                #1;
                if (out_valid) extra++;
            end
            chk({name, " extra"}, extra, 0);
        end
        chk({name, " count"}, got_pix.size(), ex_pix.size());
        for (int k = 0; k < ex_pix.size() && k < got_pix.size(); k++) begin
            chk($sformatf("%s px%0d", name, k), got_pix[k], ex_pix[k]);
            chk($sformatf("%s eof%0d", name, k), got_eof[k], ex_eof[k]);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'd77;
        in_sof    = 1'b0;
        mode      = 1'b0;
        threshold = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_pixel", out_pixel, 0);
        chk("reset out_eof", out_eof, 0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);

        // flat frame, first pixel without in_sof must still be (0,0)
        set_img(0);
        clear_q();
        add_seq(NPIX, 0, 0, 0);
        run("flat", 1'b0, 1'b0);
        chk("flat last eof", (got_eof.size() == NPIX) ? got_eof[NPIX - 1] : -1, 1);

        // vertical step: gx=1020, sq=1040400 -> 254 at centres col 3 and 4
        set_img(1);
        clear_q();
        add_seq(NPIX, 1, 0, 0);
        run("step", 1'b0, 1'b0);
        chk("step r2c4", gp(2 * LW + 4), 254);
        chk("step r4c5", gp(4 * LW + 5), 254);
        chk("step r3c6", gp(3 * LW + 6), 0);
        chk("step r1c4", gp(1 * LW + 4), 0);

        // triangle: at (4,5) gx=gy=-765, sq=1170450 -> 285 saturates to 255
        set_img(2);
        clear_q();
        add_seq(NPIX, 1, 0, 0);
        run("sat", 1'b0, 1'b0);
        chk("sat r4c5", gp(4 * LW + 5), 255);

        clear_q();
        add_seq(NPIX, 1, 1, 1170450);
        run("thr eq", 1'b0, 1'b0);
        chk("thr eq r4c5", gp(4 * LW + 5), 255);

        clear_q();
        add_seq(NPIX, 1, 1, 1170451);
        run("thr above", 1'b0, 1'b0);
        chk("thr above r4c5", gp(4 * LW + 5), 0);

        // backpressure: same step frame must come out unchanged
        set_img(1);
        clear_q();
        add_seq(NPIX, 1, 0, 0);
        run("stall", 1'b1, 1'b0);
        chk("stall r2c4", gp(2 * LW + 4), 254);

        // mid-frame in_sof at position (3,5)
        set_img(2);
        clear_q();
        add_seq(3 * LW + 5, 1, 0, 0);
        add_seq(NPIX, 1, 0, 0);
        run("midsof", 1'b0, 1'b0);
        chk("midsof r2c1", gp(3 * LW + 5 + 2 * LW + 1), 0);
        chk("midsof r4c5", gp(3 * LW + 5 + 4 * LW + 5), 255);

        // same restart point via reset: last three in-flight results are discarded
        clear_q();
        add_seq(3 * LW + 5, 1, 0, 0);
        repeat (3) begin
            void'(ex_pix.pop_back());
            void'(ex_eof.pop_back());
        end
        run("midrst", 1'b0, 1'b1);
        clear_q();
        add_seq(NPIX, 0, 0, 0);
        run("after rst", 1'b0, 1'b0);
        chk("after rst r4c5", gp(4 * LW + 5), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
